// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-facing signal bundle of the round-robin FIFO write arbiter.
// The slave side belongs to the arbiter; the master side is the producer/FIFO environment.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int OW   = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    gnt;
  logic               fifo_full;
  logic               fifo_threshold;
  logic               wr;
  logic [DW-1:0]      data_in;
  logic               busy;
  logic [OW-1:0]      owner;

  modport master (
    output req, req_data, fifo_full, fifo_threshold,
    input  ack, gnt, wr, data_in, busy, owner
  );

  modport slave (
    input  req, req_data, fifo_full, fifo_threshold,
    output ack, gnt, wr, data_in, busy, owner
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one fifo_mem write port between NREQ producers.
// One arbitration cycle in IDLE, then a burst of up to BURST_LEN beats from the granted lane.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4,
  parameter int OW        = 2
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic            req_own;
  logic [DW-1:0]   lane_own;
  logic            wr;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] rot;
  logic            found;
  logic [OW-1:0]   winner;

  // Owner lane select by compare rather than variable index, so NREQ < 2**OW stays in range.
  always_comb begin
    req_own  = 1'b0;
    lane_own = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_q == OW'(i)) begin
        req_own  = bus.req[i];
        lane_own = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Rotate requests so bit 0 is owner+1; the current owner ends up last in the search.
  always_comb begin
    int s;
    rot    = NREQ'({bus.req, bus.req} >> (int'(owner_q) + 1));
    found  = 1'b0;
    winner = owner_q;
    s      = 0;
    for (int j = 0; j < NREQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        s     = int'(owner_q) + 1 + j;
        if (s >= NREQ) s = s - NREQ;
        winner = OW'(s);
      end
    end
  end

  assign wr = (state_q == BURST) && req_own && !bus.fifo_full;

  always_comb begin
    ack = '0;
    for (int i = 0; i < NREQ; i++) ack[i] = wr && (owner_q == OW'(i));
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    gnt_d      = gnt_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (found && !bus.fifo_full && !bus.fifo_threshold) begin
          state_d    = BURST;
          owner_d    = winner;
          beat_cnt_d = '0;
          gnt_d      = NREQ'(1) << winner;
          busy_d     = 1'b1;
        end
      end
      BURST: begin
        if (wr) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (!req_own) begin
          // Early release; a fifo_full stall with req held keeps the burst.
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OW'(NREQ - 1);
      beat_cnt_q <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.wr      = wr;
  assign bus.ack     = ack;
  assign bus.data_in = lane_own;
  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.owner   = owner_q;
endmodule
